// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, latched request record, word size.
// Imported by data_mem_responder and dmem_array.
package dmem_pkg;

  localparam int DMEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 RAM: byte-enable synchronous write, registered read, no reset.
// One cycle read latency; no backpressure (the caller strobes we_i/re_i only at the commit edge).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, response WAIT_STATES+1 cycles after accept, RESP held
// until rsp_ready_i (no new request meanwhile). Optional macro DMEM_ALIGN_CHECK_EN enables error checks.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e state_q;
  dmem_req_t   req_q;
  dmem_req_t   cur_req;
  logic [3:0]  cnt_q;
  logic        ready_q, rsp_vld_q, rsp_err_q, rd_ok_q;
  logic        accept, commit, rsp_done, cur_err;
  logic [31:0] ram_rdata;

  // With zero wait states the commit edge is the accept edge, so the live request is used.
  always_comb begin
    cur_req = req_q;
    if (state_q == IDLE) begin
      cur_req = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};
    end
  end

  assign accept   = (state_q == IDLE) && req_valid_i && ready_q;
  assign commit   = (accept && (WAIT_STATES == 0)) || ((state_q == WAIT) && (cnt_q == 4'd1));
  assign rsp_done = (state_q == RESP) && rsp_ready_i;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * DMEM_WORD_BYTES);
  assign cur_err = ((cur_req.addr[1:0] != 2'b00) && (cur_req.be == 4'hF)) ||
                   (cur_req.addr >= BYTE_LIMIT);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cur_req.addr[31:AW+2], cur_req.addr[1:0]};
  assign cur_err = 1'b0;
`endif

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk_i   (clk_i),
    .we_i    (commit && cur_req.write && !cur_err),
    .re_i    (commit && !cur_req.write && !cur_err),
    .idx_i   (cur_req.addr[AW+1:2]),
    .wdata_i (cur_req.wdata),
    .be_i    (cur_req.be),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            req_q   <= cur_req;
            cnt_q   <= 4'(WAIT_STATES);
            ready_q <= 1'b0;
            state_q <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Response flags are captured at commit and held until the handshake.
      if (commit) begin
        rsp_vld_q <= 1'b1;
        rsp_err_q <= cur_err;
        rd_ok_q   <= !cur_req.write && !cur_err;
      end else if (rsp_done) begin
        rsp_vld_q <= 1'b0;
        rsp_err_q <= 1'b0;
        rd_ok_q   <= 1'b0;
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_vld_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rd_ok_q ? ram_rdata : 32'h0;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of load/store vectors plus hand-written
// sequences for reset release, response stall, address wrap/error and reset during WAIT.
module tb_data_mem_responder;

  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_STATES = 2;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic [3:0]  req_be_i = 4'h0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_STATES(WAIT_STATES)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (req_ready_o !== 1'b1 && guard < 50) begin
      @(posedge clk_i); #1;
      guard++;
    end
    chk("ready_timeout", 32'(guard < 50), 32'd1);
  endtask

  // Issues one request with rsp_ready_i high; lat counts edges from accept edge to rsp_valid_o seen.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rd, output logic er, output int lat);
    wait_ready();
    req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = d; req_be_i = be;
    @(posedge clk_i); #1;
    // Scramble request fields after accept: they must have been latched.
    req_valid_i = 1'b0; req_write_i = ~w; req_addr_i = 32'hFFFF_FFFC; req_wdata_i = 32'h5A5A_5A5A;
    req_be_i = 4'hF;
    lat = 0;
    while (rsp_valid_o !== 1'b1 && lat < 50) begin
      @(posedge clk_i); #1;
      lat++;
    end
    rd = rsp_rdata_o;
    er = rsp_err_o;
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] held;
    logic        er;
    int          lat;

    vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, "st_full_10"};
    vt[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0, "ld_10"};
    vt[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0, "st_byte0_10"};
    vt[3]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEAA, 1'b0, "ld_10_merged"};
    vt[4]  = '{1'b1, 32'h24,  32'h12345678, 4'hF, 32'h0,        1'b0, "st_full_24"};
    vt[5]  = '{1'b1, 32'h24,  32'hA5A5A5A5, 4'hA, 32'h0,        1'b0, "st_be1010_24"};
    vt[6]  = '{1'b1, 32'h24,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, "st_be0_noop"};
    vt[7]  = '{1'b0, 32'h26,  32'h0,        4'h0, 32'hA534A578, 1'b0, "ld_26_offset"};
    vt[8]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, "st_last_word"};
    vt[9]  = '{1'b0, 32'h3FC, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0, "ld_last_word"};
    vt[10] = '{1'b1, 32'h20,  32'h0BADF00D, 4'hF, 32'h0,        1'b0, "st_full_20"};
    vt[11] = '{1'b0, 32'h20,  32'h0,        4'hF, 32'h0BADF00D, 1'b0, "ld_20"};

    // Reset state, then req_ready_o rises on the first edge after release.
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'h0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b1;
    #1;
    chk("rel_ready_before_edge", 32'(req_ready_o), 32'd0);
    @(posedge clk_i); #1;
    chk("rel_ready_after_edge", 32'(req_ready_o), 32'd1);
    chk("rel_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rel_busy", 32'(busy_o), 32'd0);

    // Counting the accept cycle as cycle 1, the response appears in cycle WAIT_STATES+1,
    // i.e. WAIT_STATES edges after the accept edge.
    for (int i = 0; i < 12; i++) begin
      do_req(vt[i].w, vt[i].a, vt[i].d, vt[i].be, rd, er, lat);
      chk({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
      chk({vt[i].name, "_err"}, 32'(er), 32'(vt[i].exp_err));
      chk({vt[i].name, "_lat"}, 32'(lat), 32'(WAIT_STATES));
    end

    // Response stall: RESP holds, data stable, second request refused.
    rsp_ready_i = 1'b0;
    wait_ready();
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h10; req_be_i = 4'hF;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    lat = 0;
    while (rsp_valid_o !== 1'b1 && lat < 50) begin
      @(posedge clk_i); #1;
      lat++;
    end
    held = rsp_rdata_o;
    chk("stall_rdata", held, 32'hDEADBEAA);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h10; req_wdata_i = 32'h77777777;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      chk("stall_valid", 32'(rsp_valid_o), 32'd1);
      chk("stall_rdata_stable", rsp_rdata_o, held);
      chk("stall_ready", 32'(req_ready_o), 32'd0);
      chk("stall_busy", 32'(busy_o), 32'd1);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("stall_release_valid", 32'(rsp_valid_o), 32'd0);
    chk("stall_release_busy", 32'(busy_o), 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    chk("stall_second_not_taken", rd, 32'hDEADBEAA);

    // Address beyond the array: aliases to word 4, or errors when checking is built in.
    do_req(1'b1, 32'(DEPTH_WORDS * 4 + 'h10), 32'h55667788, 4'hF, rd, er, lat);
    chk("oob_st_lat", 32'(lat), 32'(WAIT_STATES));
    do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("oob_word4_unchanged", rd, 32'hDEADBEAA);
    do_req(1'b0, 32'(DEPTH_WORDS * 4 + 'h10), 32'h0, 4'hF, rd, er, lat);
    chk("oob_ld_err", 32'(er), 32'd1);
    chk("oob_ld_rdata", rd, 32'h0);
    do_req(1'b1, 32'h12, 32'h99999999, 4'hF, rd, er, lat);
    chk("misaligned_st_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    chk("misaligned_st_suppressed", rd, 32'hDEADBEAA);
`else
    chk("alias_word4", rd, 32'h55667788);
    do_req(1'b0, 32'(DEPTH_WORDS * 8 + 'h13), 32'h0, 4'hF, rd, er, lat);
    chk("alias_ld_err", 32'(er), 32'd0);
    chk("alias_ld_rdata", rd, 32'h55667788);
`endif

    // Reset while a store sits in WAIT: store must not reach the RAM.
    wait_ready();
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h20; req_wdata_i = 32'h11111111;
    req_be_i = 4'hF;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rstmid_in_wait_busy", 32'(busy_o), 32'd1);
    reset_i = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_ready", 32'(req_ready_o), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      chk("rstmid_valid", 32'(rsp_valid_o), 32'd0);
    end
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rstmid_ready_back", 32'(req_ready_o), 32'd1);
    do_req(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    chk("rstmid_old_contents", rd, 32'h0BADF00D);
    chk("rstmid_ld_lat", 32'(lat), 32'(WAIT_STATES));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
